// File: rtl/lfsr_link_checker.sv
// Receive-end checker: locks onto the x^8+x^6+x^5+x^4+1 LFSR byte stream, counts mismatches, flags loss of lock.
// Optional macro LINK_CHECK_AUTO_RESYNC_EN: LOST lasts one cycle and the checker returns to SYNC on its own.
module lfsr_link_checker #(
  parameter int WIDTH       = 8,
  parameter int ERR_W       = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] input_data,
  output logic             locked,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_count,
  output logic             lost
);

  typedef enum logic [1:0] {IDLE, SYNC, CHECK, LOST} state_t;

  localparam logic [3:0]       MISS_LAST = 4'(LOSS_THRESH - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [3:0]       miss_q, miss_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             flag_d;
  logic             lost_q, lost_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    exp_d   = exp_q;
    miss_d  = miss_q;
    cnt_d   = cnt_q;
    flag_d  = 1'b0;
    lost_d  = lost_q;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SYNC;
          cnt_d   = '0;
          miss_d  = '0;
          exp_d   = '0;
          lost_d  = 1'b0;
        end
        SYNC: begin
          if (in_valid && input_data != '0) begin
            exp_d   = lfsr_next(input_data);
            miss_d  = '0;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (in_valid) begin
            // Prediction free-runs so one corrupted byte costs exactly one error.
            exp_d = lfsr_next(exp_q);
            if (input_data != exp_q) begin
              flag_d = 1'b1;
              if (cnt_q != ERR_MAX) cnt_d = cnt_q + ERR_W'(1);
              miss_d = miss_q + 4'd1;
              if (miss_q == MISS_LAST) begin
                state_d = LOST;
                lost_d  = 1'b1;
              end
            end else begin
              miss_d = '0;
            end
          end
        end
        LOST: begin
`ifdef LINK_CHECK_AUTO_RESYNC_EN
          state_d = SYNC;
          lost_d  = 1'b0;
`else
          state_d = LOST;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      miss_q   <= '0;
      cnt_q    <= '0;
      err_flag <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      miss_q   <= miss_d;
      cnt_q    <= cnt_d;
      err_flag <= flag_d;
      lost_q   <= lost_d;
    end
  end

  assign locked    = (state_q == CHECK);
  assign lost      = lost_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_lfsr_link_checker.sv
// Randomized self-checking bench for lfsr_link_checker: two instances (default and ERR_W=4/LOSS_THRESH=15)
// are compared every cycle against a behavioural model of the checker rules.
module tb_lfsr_link_checker;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  input_data = 8'h00;

  logic        a_locked, a_flag, a_lost;
  logic [15:0] a_count;
  logic        b_locked, b_flag, b_lost;
  logic [3:0]  b_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  lfsr_link_checker dut_a (
    .CLK(CLK), .RST(RST), .enable(enable), .in_valid(in_valid), .input_data(input_data),
    .locked(a_locked), .err_flag(a_flag), .err_count(a_count), .lost(a_lost)
  );

  lfsr_link_checker #(.WIDTH(8), .ERR_W(4), .LOSS_THRESH(15)) dut_b (
    .CLK(CLK), .RST(RST), .enable(enable), .in_valid(in_valid), .input_data(input_data),
    .locked(b_locked), .err_flag(b_flag), .err_count(b_count), .lost(b_lost)
  );

  typedef enum {M_IDLE, M_SYNC, M_CHECK, M_LOST} mst_t;
  typedef struct {
    mst_t st;
    int   exp;
    int   miss;
    int   cnt;
    bit   flag;
    bit   lost;
  } mdl_t;

  mdl_t ma, mb;

  function automatic int mnxt(input int x);
    int fb;
    fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
    return ((x * 2) % 256) + fb;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = M_IDLE; m.exp = 0; m.miss = 0; m.cnt = 0; m.flag = 0; m.lost = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int thr, input int cmax,
                                 input bit en, input bit v, input int d);
    m.flag = 0;
    if (!en) begin
      m.st = M_IDLE;
      return m;
    end
    case (m.st)
      M_IDLE: begin
        m.st = M_SYNC; m.cnt = 0; m.miss = 0; m.exp = 0; m.lost = 0;
      end
      M_SYNC: if (v && d != 0) begin
        m.exp = mnxt(d); m.miss = 0; m.st = M_CHECK;
      end
      M_CHECK: if (v) begin
        if (d != m.exp) begin
          m.flag = 1;
          m.cnt  = (m.cnt < cmax) ? m.cnt + 1 : cmax;
          m.miss = m.miss + 1;
          if (m.miss == thr) begin
            m.st = M_LOST; m.lost = 1;
          end
        end else begin
          m.miss = 0;
        end
        m.exp = mnxt(m.exp);
      end
      M_LOST: begin
`ifdef LINK_CHECK_AUTO_RESYNC_EN
        m.st = M_SYNC; m.lost = 0;
`endif
      end
      default: m.st = M_IDLE;
    endcase
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("a_locked", a_locked, ma.st == M_CHECK);
    check("a_flag",   a_flag,   ma.flag);
    check("a_count",  a_count,  ma.cnt);
    check("a_lost",   a_lost,   ma.lost);
    check("b_locked", b_locked, mb.st == M_CHECK);
    check("b_flag",   b_flag,   mb.flag);
    check("b_count",  b_count,  mb.cnt);
    check("b_lost",   b_lost,   mb.lost);
  endtask

  task automatic tick();
    @(posedge CLK);
    ma = mstep(ma, 4, 65535, enable, in_valid, input_data);
    mb = mstep(mb, 15, 15, enable, in_valid, input_data);
    @(negedge CLK);
    compare();
  endtask

  task automatic beat(input bit v, input int d);
    in_valid   = v;
    input_data = d[7:0];
    tick();
  endtask

  task automatic restart();
    enable = 1'b0; in_valid = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    int x;
    int r;
    ma = mreset();
    mb = mreset();

    // Reset values.
    #1;
    check("rst_locked", a_locked, 0);
    check("rst_flag",   a_flag,   0);
    check("rst_count",  a_count,  0);
    check("rst_lost",   a_lost,   0);
    @(negedge CLK);
    RST = 1'b1;

    // Lock and track 300 beats with random bubbles.
    restart();
    beat(1, 'hA5);
    check("lock_after_a5", a_locked, 1);
    x = 'h4A;
    for (int i = 1; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) beat(0, $urandom_range(0, 255));
      beat(1, x);
      x = mnxt(x);
    end
    check("track_count", a_count, 0);

    // Single corruption: 4A replaced with 4B.
    restart();
    beat(1, 'hA5);
    beat(1, 'h4B);
    check("corrupt_flag", a_flag, 1);
    beat(1, 'h95);
    check("corrupt_next_ok", a_flag, 0);
    beat(1, mnxt('h95));
    check("corrupt_count", a_count, 1);
    check("corrupt_locked", a_locked, 1);

    // Loss of lock after four consecutive FF bytes.
    restart();
    beat(1, 'hA5);
    beat(1, 'h4A);
    beat(1, 'h95);
    repeat (4) beat(1, 'hFF);
    check("loss_count",  a_count,  4);
    check("loss_lost",   a_lost,   1);
    check("loss_locked", a_locked, 0);
`ifdef LINK_CHECK_AUTO_RESYNC_EN
    beat(0, 0);
    check("resync_lost", a_lost, 0);
    beat(1, 'h3C);
    check("relock", a_locked, 1);
`else
    repeat (10) beat(1, $urandom_range(1, 255));
    check("lost_holds",   a_lost,   1);
    check("lost_unlocked", a_locked, 0);
`endif

    // Zeros and bubbles in SYNC.
    restart();
    beat(1, 'h00);
    beat(1, 'h00);
    check("zero_no_lock", a_locked, 0);
    repeat (3) beat(0, $urandom_range(0, 255));
    beat(1, 'hA5);
    check("zero_lock_a5", a_locked, 1);
    beat(1, 'h4A);
    check("zero_count", a_count, 0);

    // Saturation on the 4-bit counter.
    restart();
    beat(1, 'hA5);
    repeat (20) beat(1, 'hFF);
    check("sat_count", b_count, 15);

    // Async reset mid-check with err_count=3.
    restart();
    beat(1, 'hA5);
    x = 'h4A;
    for (int i = 0; i < 6; i++) begin
      beat(1, (i % 2 == 0) ? 'hFF : x);
      x = mnxt(x);
    end
    check("pre_rst_count",  a_count,  3);
    check("pre_rst_locked", a_locked, 1);
    #2 RST = 1'b0;
    #1;
    check("arst_locked", a_locked, 0);
    check("arst_count",  a_count,  0);
    check("arst_lost",   a_lost,   0);
    check("arst_flag",   a_flag,   0);
    ma = mreset();
    mb = mreset();
    @(negedge CLK);
    RST = 1'b1;

    // Random soak against the model.
    enable = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      enable   = ($urandom_range(0, 49) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)       input_data = ma.exp[7:0];
      else if (r == 7) input_data = 8'h00;
      else             input_data = 8'($urandom_range(0, 255));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
